crank_wheel_gen: RTL and testbench

//  Synthesises a toothed-crank sensor waveform (default 60-2) from a programmable per-tooth period.
//  It is the encoder counterpart of the crank-decoding angle generator.

---
 rtl/crank_wheel_gen.sv | 88 ++++++++
 tb/tb_crank_wheel_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: toothed-crank (60-2) waveform synthesiser; in: clk, rst, enable_i, invert_i, period_i; out: cap_out_o, tooth_num_o, gap_o, rev_pulse_o, running_o
module crank_wheel_gen #(
  parameter int PER_WIDTH     = 24,
  parameter int TEETH_TOTAL   = 60,
  parameter int TEETH_MISSING = 2,
  parameter int TCNT_WIDTH    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  invert_i,
  input  logic [PER_WIDTH-1:0]  period_i,
  output logic                  cap_out_o,
  output logic [TCNT_WIDTH-1:0] tooth_num_o,
  output logic                  gap_o,
  output logic                  rev_pulse_o,
  output logic                  running_o
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;
  localparam logic [TCNT_WIDTH-1:0] LAST_SLOT = TCNT_WIDTH'(TEETH_TOTAL - 1);
  localparam logic [TCNT_WIDTH-1:0] FIRST_GAP = TCNT_WIDTH'(TEETH_TOTAL - TEETH_MISSING);
  state_t                state_q, state_d;
  logic [PER_WIDTH-1:0]  per_q, per_d, half_q, half_d, tick_q, tick_d;
  logic [TCNT_WIDTH-1:0] slot_q, slot_d, next_slot;
  logic                  per_ok, slot_end;
  assign per_ok    = period_i >= PER_WIDTH'(2);
  assign slot_end  = tick_q == per_q - PER_WIDTH'(1);
  assign next_slot = slot_q == LAST_SLOT ? '0 : slot_q + TCNT_WIDTH'(1);
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    half_d  = half_q;
    tick_d  = tick_q + PER_WIDTH'(1);
    slot_d  = slot_q;
    if (!enable_i) begin
      state_d = IDLE;
      tick_d  = '0;
      slot_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tick_d = '0;
          slot_d = '0;
          if (per_ok) begin
            state_d = HIGH;
            per_d   = period_i;
            half_d  = period_i >> 1;
          end
        end
        HIGH: state_d = tick_q == half_q - PER_WIDTH'(1) ? LOW : HIGH;
        default: if (slot_end) begin
          // Slot boundary: period is re-sampled here only, so mid-slot writes never shorten a slot.
          tick_d  = '0;
          per_d   = period_i;
          half_d  = period_i >> 1;
          slot_d  = per_ok ? next_slot : '0;
          state_d = !per_ok ? IDLE : (next_slot >= FIRST_GAP ? GAP : HIGH);
        end
      endcase
    end
  end
  // Outputs are registered from the next state so they appear together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      per_q       <= '0;
      half_q      <= '0;
      tick_q      <= '0;
      slot_q      <= '0;
      cap_out_o   <= invert_i;
      tooth_num_o <= '0;
      gap_o       <= 1'b0;
      rev_pulse_o <= 1'b0;
      running_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      half_q      <= half_d;
      tick_q      <= tick_d;
      slot_q      <= slot_d;
      cap_out_o   <= (state_d == HIGH) ^ invert_i;
      tooth_num_o <= slot_d;
      gap_o       <= state_d == GAP;
      rev_pulse_o <= state_d == HIGH && slot_d == '0 && tick_d == '0;
      running_o   <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_crank_wheel_gen.sv
// tb_crank_wheel_gen: table-driven and sequence checks for crank_wheel_gen
module tb_crank_wheel_gen;
  logic        clk = 0, rst = 1, en = 0, inv = 0;
  logic [23:0] per = 24'd4;
  logic        cap, gap, rev, run;
  logic [5:0]  tooth;
  int          checks = 0, failures = 0;

  crank_wheel_gen dut (
    .clk(clk), .rst(rst), .enable_i(en), .invert_i(inv), .period_i(per),
    .cap_out_o(cap), .tooth_num_o(tooth), .gap_o(gap), .rev_pulse_o(rev), .running_o(run)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, inv; logic [23:0] per; int n;
    logic cap; logic [5:0] tooth; logic gap, rev, run;
  } vec_t;
  vec_t v[21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic c, input logic [5:0] t, input logic g, input logic r, input logic u);
    checks++;
    if ({cap, tooth, gap, rev, run} != {c, t, g, r, u}) begin
      failures++;
      $display("FAIL %s got cap=%b tooth=%0d gap=%b rev=%b run=%b expected cap=%b tooth=%0d gap=%b rev=%b run=%b",
               name, cap, tooth, gap, rev, run, c, t, g, r, u);
    end
  endtask

  initial begin
    int len, hi, rises, lowrun, maxlow, w;
    logic prev;
    // period 4: two high, two low per slot; slot s starts at edge 1+4s
    v[0]  = '{1, 0, 24'd4, 1,   1, 0,  0, 1, 1};
    v[1]  = '{1, 0, 24'd4, 1,   1, 0,  0, 0, 1};
    v[2]  = '{1, 0, 24'd4, 1,   0, 0,  0, 0, 1};
    v[3]  = '{1, 0, 24'd4, 1,   0, 0,  0, 0, 1};
    v[4]  = '{1, 0, 24'd4, 1,   1, 1,  0, 0, 1};
    v[5]  = '{1, 0, 24'd4, 228, 0, 58, 1, 0, 1};
    v[6]  = '{1, 0, 24'd4, 4,   0, 59, 1, 0, 1};
    v[7]  = '{1, 0, 24'd4, 3,   0, 59, 1, 0, 1};
    v[8]  = '{1, 0, 24'd4, 1,   1, 0,  0, 1, 1};
    v[9]  = '{1, 0, 24'd4, 1,   1, 0,  0, 0, 1};
    v[10] = '{1, 1, 24'd4, 3,   0, 1,  0, 0, 1};
    v[11] = '{0, 0, 24'd4, 1,   0, 0,  0, 0, 0};
    v[12] = '{0, 1, 24'd4, 1,   1, 0,  0, 0, 0};
    v[13] = '{1, 0, 24'd1, 3,   0, 0,  0, 0, 0};
    v[14] = '{1, 0, 24'd3, 1,   1, 0,  0, 1, 1};
    v[15] = '{1, 0, 24'd3, 1,   0, 0,  0, 0, 1};
    v[16] = '{1, 0, 24'd3, 1,   0, 0,  0, 0, 1};
    v[17] = '{1, 0, 24'd3, 1,   1, 1,  0, 0, 1};
    v[18] = '{1, 0, 24'd0, 1,   0, 1,  0, 0, 1};
    v[19] = '{1, 0, 24'd0, 1,   0, 1,  0, 0, 1};
    v[20] = '{1, 0, 24'd0, 1,   0, 0,  0, 0, 0};

    tick();
    chk_out("reset", 0, 0, 0, 0, 0);
    rst = 0;
    foreach (v[i]) begin
      en = v[i].en; inv = v[i].inv; per = v[i].per;
      repeat (v[i].n) tick();
      chk_out($sformatf("vec%0d", i), v[i].cap, v[i].tooth, v[i].gap, v[i].rev, v[i].run);
    end

    // full revolution at period 100
    rst = 1; en = 0; inv = 0; per = 24'd100;
    tick();
    rst = 0; en = 1;
    tick();
    chk_out("rev_start", 1, 0, 0, 1, 1);
    len = 0; rises = 0; lowrun = 0; maxlow = 0; prev = cap;
    do begin
      tick();
      len++;
      if (cap && !prev) rises++;
      lowrun = cap ? 0 : lowrun + 1;
      if (lowrun > maxlow) maxlow = lowrun;
      prev = cap;
    end while (!rev && len < 10000);
    chk("rev_length", len, 6000);
    chk("rising_edges", rises, 58);
    chk("gap_low_stretch", maxlow, 250);

    // period change mid-slot 10 applies from slot 11
    w = 0;
    while (tooth != 6'd10 && w < 20000) begin tick(); w++; end
    chk("reach_slot10", tooth, 10);
    len = 0;
    while (tooth == 6'd10 && len < 1000) begin
      len++;
      if (len == 30) per = 24'd200;
      tick();
    end
    chk("slot10_len", len, 100);
    len = 0; hi = 0;
    while (tooth == 6'd11 && len < 1000) begin
      len++;
      hi += int'(cap);
      tick();
    end
    chk("slot11_len", len, 200);
    chk("slot11_high", hi, 100);

    // inverted output, reset mid-gap
    rst = 1; en = 0; inv = 1; per = 24'd10;
    tick();
    chk_out("reset_inv", 1, 0, 0, 0, 0);
    rst = 0; en = 1;
    tick();
    chk_out("inv_start", 0, 0, 0, 1, 1);
    w = 0;
    while (tooth != 6'd58 && w < 2000) begin tick(); w++; end
    tick(); tick(); tick();
    chk_out("inv_gap", 1, 58, 1, 0, 1);
    rst = 1;
    tick();
    chk_out("rst_mid_gap", 1, 0, 0, 0, 0);
    rst = 0; en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
